ac97_sout: RTL and testbench

AC97_SOUT -- requirements
Module: ac97_sout

---
 rtl/ac97_sout.sv | 104 ++++++++++
 tb/tb_ac97_sout.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ac97_sout.sv
// AC97 serial output framer: 256-bit frames with SYNC, MSB-first slot data,
// a frame-start pulse and per-slot load strobes for the serial input side.
module ac97_sout #(
  parameter int unsigned LE_OFS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] slt0,
  input  logic [19:0] slt1,
  input  logic [19:0] slt2,
  input  logic [19:0] slt3,
  input  logic [19:0] slt4,
  output logic        sync,
  output logic        sdata_out,
  output logic        frame_start,
  output logic [4:0]  out_le,
  output logic        busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic        state_q, state_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [95:0] hold_q, hold_d;
  logic        sync_q, sync_d;
  logic        sdata_q, sdata_d;
  logic        frame_start_q, frame_start_d;
  logic [4:0]  out_le_q, out_le_d;
  logic        busy_q, busy_d;
  logic        run_d;
  logic [6:0]  bit_idx;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    hold_d    = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_RUN;
          bit_cnt_d = 8'd255;
        end
      end
      default: begin
        // en only matters on the edge leaving bit 254; elsewhere the frame runs on
        if (bit_cnt_q == 8'd254 && !en) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (bit_cnt_q == 8'd255) begin
            hold_d = {slt0, slt1, slt2, slt3, slt4};
          end
        end
      end
    endcase

    // Outputs are derived from next-state values so the registered pins line
    // up with the bit counter of the cycle they are presented in.
    run_d         = (state_d == ST_RUN);
    busy_d        = run_d;
    sync_d        = run_d && (bit_cnt_d == 8'd255 || bit_cnt_d <= 8'd14);
    frame_start_d = run_d && (bit_cnt_d == 8'd0);
    bit_idx       = 7'(8'd95 - bit_cnt_d);
    sdata_d       = 1'b0;
    if (run_d && bit_cnt_d < 8'd96) begin
      sdata_d = hold_d[bit_idx];
    end
    for (int unsigned k = 0; k < 5; k++) begin
      out_le_d[k] = run_d && (bit_cnt_d == 8'(15 + 20 * k + LE_OFS));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      hold_q        <= '0;
      sync_q        <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      out_le_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      hold_q        <= hold_d;
      sync_q        <= sync_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      out_le_q      <= out_le_d;
      busy_q        <= busy_d;
    end
  end

  assign sync        = sync_q;
  assign sdata_out   = sdata_q;
  assign frame_start = frame_start_q;
  assign out_le      = out_le_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ac97_sout.sv
// Directed bench for ac97_sout: frame layout, input capture, en/rst sequencing.
module tb_ac97_sout;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] slt0;
  logic [19:0] slt1, slt2, slt3, slt4;
  logic        sync, sdata_out, frame_start, busy;
  logic [4:0]  out_le;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [95:0] f1, f2;
  logic [8:0]  obs;
  logic [8:0]  exp_v;

  ac97_sout #(.LE_OFS(1)) dut (
    .clk(clk), .rst(rst), .en(en),
    .slt0(slt0), .slt1(slt1), .slt2(slt2), .slt3(slt3), .slt4(slt4),
    .sync(sync), .sdata_out(sdata_out), .frame_start(frame_start),
    .out_le(out_le), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected {busy, sync, sdata, frame_start, out_le} in a RUN cycle at bit b
  function automatic logic [8:0] exp_run(input int unsigned b, input logic [95:0] f);
    logic [4:0] le;
    logic       sd;
    le = {b == 96, b == 76, b == 56, b == 36, b == 16};
    sd = (b < 96) ? f[95 - b] : 1'b0;
    return {1'b1, (b == 255 || b <= 14), sd, b == 0, le};
  endfunction

  task automatic check(input string tag, input int unsigned b, input logic [8:0] expected);
    obs = {busy, sync, sdata_out, frame_start, out_le};
    total++;
    assert (obs === expected) else begin
      bad++;
      $error("FAIL %s bit=%0d observed=%b expected=%b", tag, b, obs, expected);
    end
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b1;
    slt0 = 16'hF800;
    slt1 = 20'hA5A5A;
    slt2 = 20'h12345;
    slt3 = 20'hFFFFF;
    slt4 = 20'h00001;
    f1   = {16'hF800, 20'hA5A5A, 20'h12345, 20'hFFFFF, 20'h00001};
    f2   = {16'hF800, 20'h5A5A5, 20'h12345, 20'hFFFFF, 20'h00001};

    // reset holds everything low even with en=1
    repeat (3) begin
      tick;
      check("reset", 0, 9'b0);
    end

    // frame 1: slot words reproduced; slt1 changed at bit 40 must not leak in
    rst = 1'b1;
    tick;
    check("pre1", 255, exp_run(255, f1));
    for (int unsigned b = 0; b < 255; b++) begin
      tick;
      check("frame1", b, exp_run(b, f1));
      if (b == 40) slt1 = 20'h5A5A5;
    end

    // frame 2 carries the new slt1; en dropped at bit 100 still completes
    tick;
    check("pre2", 255, exp_run(255, f1));
    for (int unsigned b = 0; b < 255; b++) begin
      tick;
      check("frame2", b, exp_run(b, f2));
      if (b == 100) en = 1'b0;
    end
    repeat (3) begin
      tick;
      check("idle_after_drop", 0, 9'b0);
    end

    // restart; en dropped during preamble 255 lets the next frame run fully
    en = 1'b1;
    tick;
    check("pre3", 255, exp_run(255, f2));
    for (int unsigned b = 0; b < 255; b++) begin
      tick;
      check("frame3", b, exp_run(b, f2));
    end
    tick;
    check("pre4", 255, exp_run(255, f2));
    en = 1'b0;
    for (int unsigned b = 0; b < 255; b++) begin
      tick;
      check("frame4", b, exp_run(b, f2));
    end
    repeat (2) begin
      tick;
      check("idle_after_frame4", 0, 9'b0);
    end

    // reset mid-frame at bit 20 aborts immediately, then restart from preamble
    en = 1'b1;
    tick;
    check("pre5", 255, exp_run(255, f2));
    for (int unsigned b = 0; b <= 20; b++) begin
      tick;
      check("frame5", b, exp_run(b, f2));
      if (b == 20) rst = 1'b0;
    end
    tick;
    check("rst_abort", 0, 9'b0);
    tick;
    check("rst_hold", 0, 9'b0);
    rst = 1'b1;
    tick;
    check("pre6", 255, exp_run(255, f2));
    for (int unsigned b = 0; b <= 20; b++) begin
      tick;
      check("frame6", b, exp_run(b, f2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
